// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared stage bundle widths and bubble constants for the pipeline buffers
package pipe_pkg;

   localparam int PC_W       = 16;
   localparam int REG_ADDR_W = 4;
   localparam int IMM_W      = 8;
   localparam int ALUOP_W    = 3;
   localparam int INSTR_W    = 32;
   localparam int XLEN       = 16;
   localparam int CTRL_W     = 17;

   // Per-stage bundle widths, derived from the field widths above
   localparam int IF_ID_W  = PC_W + INSTR_W + PC_W;
   localparam int ID_EX_W  = PC_W + 2 * XLEN + 3 * REG_ADDR_W + IMM_W + ALUOP_W + CTRL_W;
   localparam int EX_MEM_W = PC_W + 2 * XLEN + REG_ADDR_W + CTRL_W;
   localparam int MEM_WB_W = XLEN + REG_ADDR_W + CTRL_W;

   // A bubble is an all-zero bundle: every control bit inactive
   localparam logic [IF_ID_W-1:0]  IF_ID_BUBBLE  = '0;
   localparam logic [ID_EX_W-1:0]  ID_EX_BUBBLE  = '0;
   localparam logic [EX_MEM_W-1:0] EX_MEM_BUBBLE = '0;
   localparam logic [MEM_WB_W-1:0] MEM_WB_BUBBLE = '0;

   // Field layout of the ID/EX bundle, the widest stage
   typedef struct packed {
      logic [PC_W-1:0]       pc;
      logic [XLEN-1:0]       op_a;
      logic [XLEN-1:0]       op_b;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic [IMM_W-1:0]      imm;
      logic [ALUOP_W-1:0]    aluop;
      logic [CTRL_W-1:0]     ctrl;
   } id_ex_t;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - upstream/downstream valid-ready handshake of one pipeline stage buffer
interface pipe_stage_buf_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = ID_EX_W
) ();

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   // Driver side: produces upstream bundles and consumes the head
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Buffer side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - one bundle register with valid bit and load/clear controls
module pipe_skid_entry
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = ID_EX_W,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              valid_d, valid_q;
   logic [DATA_W-1:0] data_d, data_q;

   // Clear wins over load; data is kept on clear so a stale head can still be shown
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end
   end

   // Entry state register
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= RESET_VAL;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - inter-stage pipeline buffer with handshake, optional skid entry and hazard tags
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int                DATA_W          = ID_EX_W,
   parameter int                SKID            = 1,
   parameter logic [DATA_W-1:0] BUBBLE_VAL      = ID_EX_BUBBLE,
   parameter int                CLEAR_ON_BUBBLE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                stall,
   pipe_stage_buf_if.slave     bus,
   output logic                post_stall,
   output logic                post_flush,
   output logic [1:0]          occupancy
);

   logic              main_v, skid_v;
   logic [DATA_W-1:0] main_data, skid_data;
   logic              main_load, main_clear, skid_load, skid_clear;
   logic [DATA_W-1:0] main_din;
   logic              skid_v_next;
   logic              push, pop;
   logic              in_ready_d, in_ready_q;
   logic              post_stall_d, post_stall_q;
   logic              post_flush_d, post_flush_q;

   // With the skid entry, ready depends only on registered state, never on out_ready
   assign bus.in_ready = !stall && ((SKID != 0) ? in_ready_q : (!main_v || bus.out_ready));

   assign push = bus.in_valid && bus.in_ready && !stall && !flush;
   assign pop  = main_v && bus.out_ready && !flush;

   // Occupancy control: decide which entry loads or empties this cycle
   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      main_din   = bus.in_data;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else if (SKID != 0) begin
         if (skid_v) begin
            // Full: only a pop can happen, the second entry advances to the head
            if (pop) begin
               main_load  = 1'b1;
               main_din   = skid_data;
               skid_clear = 1'b1;
            end
         end else if (main_v) begin
            if (push && pop) begin
               main_load = 1'b1;
            end else if (push) begin
               skid_load = 1'b1;
            end else if (pop) begin
               main_clear = 1'b1;
            end
         end else if (push) begin
            main_load = 1'b1;
         end
      end else begin
         if (push) begin
            main_load = 1'b1;
         end else if (pop) begin
            main_clear = 1'b1;
         end
      end
   end

   // Next-state view of the second entry, used to register ready ahead of time
   always_comb begin
      skid_v_next = skid_v;
      if (skid_clear) begin
         skid_v_next = 1'b0;
      end else if (skid_load) begin
         skid_v_next = 1'b1;
      end
      in_ready_d   = !skid_v_next;
      post_stall_d = stall && !flush;
      post_flush_d = flush;
   end

   // Registered ready and one-cycle hazard tags
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_q   <= 1'b1;
         post_stall_q <= 1'b0;
         post_flush_q <= 1'b0;
      end else begin
         in_ready_q   <= in_ready_d;
         post_stall_q <= post_stall_d;
         post_flush_q <= post_flush_d;
      end
   end

   pipe_skid_entry #(
      .DATA_W    (DATA_W),
      .RESET_VAL (BUBBLE_VAL)
   ) u_main (
      .clk       (clk),
      .rst       (rst),
      .load      (main_load),
      .clear     (main_clear),
      .load_data (main_din),
      .valid     (main_v),
      .data      (main_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_skid_entry #(
            .DATA_W    (DATA_W),
            .RESET_VAL (BUBBLE_VAL)
         ) u_skid (
            .clk       (clk),
            .rst       (rst),
            .load      (skid_load),
            .clear     (skid_clear),
            .load_data (bus.in_data),
            .valid     (skid_v),
            .data      (skid_data)
         );
      end else begin : g_no_skid
         assign skid_v    = 1'b0;
         assign skid_data = BUBBLE_VAL;
      end
   endgenerate

   assign bus.out_valid = main_v;
   assign bus.out_data  = (main_v || (CLEAR_ON_BUBBLE == 0)) ? main_data : BUBBLE_VAL;
   assign occupancy     = {1'b0, main_v} + {1'b0, skid_v};
   assign post_stall    = post_stall_q;
   assign post_flush    = post_flush_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf in skid and single-register forms
module tb_pipe_stage_buf;

   localparam int W = 88;

   logic         clk = 1'b0;
   logic         rst;
   logic         st1, fl1, st0, fl0;
   logic         ps1, pf1, ps0, pf0;
   logic [1:0]   occ1, occ0;
   logic [W-1:0] q1[$];
   logic [W-1:0] q0[$];
   int           tests = 0;
   int           fails = 0;

   pipe_stage_buf_if #(.DATA_W(W)) bus1 ();
   pipe_stage_buf_if #(.DATA_W(W)) bus0 ();

   pipe_stage_buf #(.DATA_W(W), .SKID(1)) dut1 (
      .clk(clk), .rst(rst), .flush(fl1), .stall(st1), .bus(bus1),
      .post_stall(ps1), .post_flush(pf1), .occupancy(occ1)
   );

   pipe_stage_buf #(.DATA_W(W), .SKID(0)) dut0 (
      .clk(clk), .rst(rst), .flush(fl0), .stall(st0), .bus(bus0),
      .post_stall(ps0), .post_flush(pf0), .occupancy(occ0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitors: every consumed head must be the oldest expected bundle
   always @(negedge clk) begin
      if (!rst && bus1.out_valid === 1'b1 && bus1.out_ready && !fl1) begin
         if (q1.size() == 0) begin
            chk("skid1_unexpected_out", bus1.out_data, '1);
         end else begin
            chk("skid1_scoreboard", bus1.out_data, q1.pop_front());
         end
      end
      if (!rst && bus0.out_valid === 1'b1 && bus0.out_ready && !fl0) begin
         if (q0.size() == 0) begin
            chk("skid0_unexpected_out", bus0.out_data, '1);
         end else begin
            chk("skid0_scoreboard", bus0.out_data, q0.pop_front());
         end
      end
   end

   task automatic cyc1(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic st, input logic fl, input logic exp_push);
      @(posedge clk);
      #1;
      bus1.in_valid  = v;
      bus1.in_data   = d;
      bus1.out_ready = ordy;
      st1 = st;
      fl1 = fl;
      if (fl) q1.delete();
      if (exp_push) q1.push_back(d);
      @(negedge clk);
   endtask

   task automatic cyc0(input logic v, input logic [W-1:0] d, input logic ordy, input logic exp_push);
      @(posedge clk);
      #1;
      bus0.in_valid  = v;
      bus0.in_data   = d;
      bus0.out_ready = ordy;
      if (exp_push) q0.push_back(d);
      @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] va, vb, vc, vd, ve, vx, vy, vz;
      va = {11{8'hA5}};
      vb = {11{8'h3C}};
      vc = {22{4'hC}};
      vd = {22{4'hD}};
      ve = {22{4'hE}};
      vx = 88'h0123_4567_89AB_CDEF_0011_22;
      vy = 88'hFEDC_BA98_7654_3210_FFEE_DD;
      vz = 88'h5555_AAAA_5555_AAAA_5555_AA;

      rst = 1'b1;
      st1 = 1'b0; fl1 = 1'b0; st0 = 1'b0; fl0 = 1'b0;
      bus1.in_valid = 1'b1; bus1.in_data = 88'h5A; bus1.out_ready = 1'b0;
      bus0.in_valid = 1'b1; bus0.in_data = 88'h5A; bus0.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus1.in_valid = 1'b0;
      bus0.in_valid = 1'b0;
      @(negedge clk);
      chk("rst_occupancy", W'(occ1), 0);
      chk("rst_out_valid", W'(bus1.out_valid), 0);
      chk("rst_out_data", bus1.out_data, 0);
      chk("rst_post_stall", W'(ps1), 0);
      chk("rst_post_flush", W'(pf1), 0);
      chk("rst_in_ready", W'(bus1.in_ready), 1);
      chk("rst_in_ready_skid0", W'(bus0.in_ready), 1);

      // Streaming 1..4 with the sink always ready
      for (int i = 1; i <= 4; i++) begin
         cyc1(1'b1, W'(i), 1'b1, 1'b0, 1'b0, 1'b1);
         chk("stream_in_ready", W'(bus1.in_ready), 1);
         if (i > 1) begin
            chk("stream_out_valid", W'(bus1.out_valid), 1);
            chk("stream_occupancy", W'(occ1), 1);
         end
      end
      cyc1(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("stream_last_valid", W'(bus1.out_valid), 1);
      cyc1(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("stream_drained_valid", W'(bus1.out_valid), 0);
      chk("stream_drained_occ", W'(occ1), 0);

      // Back-pressure fills both entries
      cyc1(1'b1, va, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc1(1'b1, vb, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("bp_in_ready_occ1", W'(bus1.in_ready), 1);
      cyc1(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp_full_occ", W'(occ1), 2);
      chk("bp_full_in_ready", W'(bus1.in_ready), 0);
      chk("bp_full_head", bus1.out_data, va);
      cyc1(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("bp_pop_in_ready", W'(bus1.in_ready), 0);
      cyc1(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("bp_second_occ", W'(occ1), 1);
      chk("bp_second_in_ready", W'(bus1.in_ready), 1);
      cyc1(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("bp_empty_valid", W'(bus1.out_valid), 0);
      chk("bp_empty_data", bus1.out_data, 0);

      // Stall inserts a bubble; the held bundle follows a cycle later
      cyc1(1'b1, 88'h11, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc1(1'b1, 88'h12, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("stall_in_ready", W'(bus1.in_ready), 0);
      cyc1(1'b1, 88'h12, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("stall_bubble_valid", W'(bus1.out_valid), 0);
      chk("stall_bubble_data", bus1.out_data, 0);
      chk("stall_post_stall", W'(ps1), 1);
      chk("stall_post_flush", W'(pf1), 0);
      cyc1(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("stall_resume_valid", W'(bus1.out_valid), 1);
      chk("stall_tag_cleared", W'(ps1), 0);
      cyc1(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Flush while full, with a concurrent push attempt and stall
      cyc1(1'b1, vc, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc1(1'b1, vd, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc1(1'b1, ve, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("flush_pre_occ", W'(occ1), 2);
      cyc1(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("flush_occ", W'(occ1), 0);
      chk("flush_out_valid", W'(bus1.out_valid), 0);
      chk("flush_out_data", bus1.out_data, 0);
      chk("flush_post_flush", W'(pf1), 1);
      chk("flush_post_stall", W'(ps1), 0);
      chk("flush_in_ready", W'(bus1.in_ready), 1);
      cyc1(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("flush_tag_cleared", W'(pf1), 0);
      chk("flush_still_empty", W'(bus1.out_valid), 0);

      // Single-register variant: ready follows out_ready when occupied
      cyc0(1'b1, vx, 1'b0, 1'b1);
      cyc0(1'b1, vy, 1'b1, 1'b1);
      chk("s0_occ_replace", W'(occ0), 1);
      chk("s0_in_ready_pop", W'(bus0.in_ready), 1);
      cyc0(1'b1, vz, 1'b0, 1'b0);
      chk("s0_in_ready_block", W'(bus0.in_ready), 0);
      chk("s0_head_replaced", bus0.out_data, vy);
      cyc0(1'b0, 0, 1'b1, 1'b0);
      chk("s0_occ_held", W'(occ0), 1);
      cyc0(1'b0, 0, 1'b0, 1'b0);
      chk("s0_empty_occ", W'(occ0), 0);
      chk("s0_empty_valid", W'(bus0.out_valid), 0);

      chk("skid1_queue_drained", W'(q1.size()), 0);
      chk("skid0_queue_drained", W'(q0.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor of our fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed control/data bundle of DATA_W bits between two pipeline stages.
- Adds a valid/ready handshake and an optional 2-entry skid buffer, so back-pressure does not need a combinational ready path.
- Keeps the existing hazard-unit semantics: stall inserts a bubble, flush kills everything in flight, and one-cycle post_stall/post_flush tags are provided for downstream forwarding logic.

Parameters:
- DATA_W, 88, width of the packed stage bundle.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register, in_ready = !full || out_ready.
- BUBBLE_VAL, 0 (DATA_W bits), value driven on out_data whenever out_valid=0.
- CLEAR_ON_BUBBLE, 1, 1 = out_data forced to BUBBLE_VAL when not valid; 0 = stale data held.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all held and incoming entries.
- stall  in  1  hazard stall: accept nothing this cycle, insert a bubble.
- in_valid  in  1  upstream bundle valid.
- in_data  in  DATA_W  upstream bundle.
- in_ready  out  1  stage can accept this cycle.
- out_valid  out  1  out_data holds a live bundle.
- out_data  out  DATA_W  head bundle.
- out_ready  in  1  downstream consumes the head this cycle.
- post_stall  out  1  previous cycle had stall=1 with no flush.
- post_flush  out  1  previous cycle had flush=1.
- occupancy  out  2  live entries held (0..2; never exceeds 1 when SKID=0).

Behaviour:
- Reset (rst=1 at clock edge) has the highest priority.
  - Entries are emptied: occupancy=0, out_valid=0, out_data=BUBBLE_VAL, post_stall=0, post_flush=0.
  - in_ready is 1 in the cycle after reset. Reset during a transfer discards it; no partial state is kept.
- Event definitions:
  - push = in_valid && in_ready && !stall && !flush
  - pop = out_valid && out_ready && !flush
- Priority: rst > flush > stall > normal handshake.
- Flush:
  - Next cycle: occupancy=0, out_valid=0, post_flush=1, post_stall=0.
  - Concurrent stall, push and pop are all ignored.
- Stall (without flush):
  - push is suppressed; pop is still allowed.
  - If the head empties or was already empty, a bubble appears on the output.
  - post_stall=1 next cycle.
- in_ready:
  - SKID=1: in_ready = (occupancy<2), registered, with no combinational path from out_ready.
  - SKID=0: in_ready = (occupancy==0) || out_ready.
  - Both cases are additionally gated low while stall=1.
- Data latency: one cycle from push to out_valid when the stage is empty. Data is never bypassed combinationally.
- Occupancy transitions (SKID=1; main = head register, skid = second register):
  - 0, push -> 1; the bundle is loaded into main.
  - 1, push & pop -> 1; main is replaced by the new bundle.
  - 1, push only -> 2; the bundle is loaded into skid.
  - 1, pop only -> 0.
  - 2, pop -> 1; skid moves to main. Push is impossible because in_ready=0.
  - 2, no pop -> 2; both entries held, in_ready=0.
- Ordering is strictly FIFO; no bundle is duplicated or dropped except by flush or rst.
- out_data:
  - Equals main when out_valid=1.
  - Equals BUBBLE_VAL when out_valid=0 and CLEAR_ON_BUBBLE=1.
- post_stall and post_flush are pure one-cycle registered copies; they never overlap because flush wins.

Decomposition:
- Shared package pipe_pkg holds:
  - the stage bundle widths (PC_W=16, REG_ADDR_W=4, IMM_W=8, ALUOP_W=3) and the per-stage DATA_W constants computed from them;
  - the BUBBLE_VAL constant for each stage.
- One sub-module, pipe_skid_entry: a single register holding data and a valid bit, with load/clear controls. It is instanced twice when SKID=1 and once when SKID=0.
- The occupancy control stays in pipe_stage_buf.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 and in_data=0x5A -> occupancy=0, out_valid=0, out_data=0, post_flags=0, in_ready=1 after release.
- Streaming: in_data=1,2,3,4 on consecutive cycles with out_ready=1 -> out_data 1,2,3,4 each one cycle later; occupancy stays 1; no gaps.
- Back-pressure (SKID=1): push A, B with out_ready=0 -> occupancy=2, in_ready=0; then out_ready=1 -> A, then B, then out_valid=0.
- Stall bubble: streaming with stall=1 for one cycle -> no push that cycle; out_valid=0 the next cycle with post_stall=1; the held upstream bundle follows one cycle later.
- Flush with occupancy=2 plus simultaneous push/stall -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VAL, post_flush=1, post_stall=0; the pushed bundle is never seen.
- SKID=0 variant: occupancy=1, out_ready=1 and push in the same cycle -> in_ready=1 and the head is replaced; with out_ready=0 -> in_ready=0 and occupancy stays 1.
